// File: rtl/icache_fetch_buffer_pkg.sv
// Shared types and defaults for the I$ fetch buffer: queued entry layout,
// flush FSM encoding and default geometry.
package icache_fetch_buffer_pkg;

    localparam int unsigned FB_DEPTH_DEFAULT = 4;
    localparam int unsigned FETCH_WIDTH      = 32;
    localparam int unsigned VLEN             = 64;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] data;
        logic [VLEN-1:0]        vaddr;
        logic                   ex;
    } fetch_entry_t;

    typedef enum logic {
        FB_RUN   = 1'b0,
        FB_FLUSH = 1'b1
    } fb_state_e;

endpackage

// File: rtl/icache_fetch_buffer_if.sv
// Bundles the PC-gen request, I$ request/response and realigner handshakes.
// Signal suffixes are relative to the fetch buffer (slave side).
interface icache_fetch_buffer_if #(
    parameter int unsigned FetchWidth = icache_fetch_buffer_pkg::FETCH_WIDTH,
    parameter int unsigned VLen       = icache_fetch_buffer_pkg::VLEN
) ();

    logic                  req_valid_i;
    logic [VLen-1:0]       req_vaddr_i;
    logic                  req_ready_o;

    logic                  icache_req_o;
    logic [VLen-1:0]       icache_vaddr_o;
    logic                  icache_kill_s1_o;
    logic                  icache_kill_s2_o;
    logic                  icache_ready_i;
    logic                  icache_valid_i;
    logic [FetchWidth-1:0] icache_data_i;
    logic [VLen-1:0]       icache_vaddr_i;
    logic                  icache_ex_i;

    logic                  fetch_valid_o;
    logic [FetchWidth-1:0] fetch_data_o;
    logic [VLen-1:0]       fetch_vaddr_o;
    logic                  fetch_ex_o;
    logic                  fetch_ready_i;

    modport slave (
        input  req_valid_i, req_vaddr_i,
        output req_ready_o,
        output icache_req_o, icache_vaddr_o, icache_kill_s1_o, icache_kill_s2_o,
        input  icache_ready_i, icache_valid_i, icache_data_i, icache_vaddr_i, icache_ex_i,
        output fetch_valid_o, fetch_data_o, fetch_vaddr_o, fetch_ex_o,
        input  fetch_ready_i
    );

    modport master (
        output req_valid_i, req_vaddr_i,
        input  req_ready_o,
        input  icache_req_o, icache_vaddr_o, icache_kill_s1_o, icache_kill_s2_o,
        output icache_ready_i, icache_valid_i, icache_data_i, icache_vaddr_i, icache_ex_i,
        input  fetch_valid_o, fetch_data_o, fetch_vaddr_o, fetch_ex_o,
        output fetch_ready_i
    );

endinterface

// File: rtl/icache_fetch_buffer_fetch_fifo.sv
// Generic synchronous FIFO with flush and occupancy count; read data is the
// registered head entry, so a pushed word is visible the cycle after the push.
module fetch_fifo #(
    parameter int unsigned Depth = 4,
    parameter type entry_t = logic [31:0],
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  entry_t          data_i,
    input  logic            pop_i,
    output entry_t          data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    entry_t          mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because Depth is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/icache_fetch_buffer.sv
// Credit-managed fetch buffer: an I$ request is only issued when a FIFO slot
// is reserved for its response, since the I$ response path cannot stall.
module icache_fetch_buffer
    import icache_fetch_buffer_pkg::*;
#(
    parameter int unsigned Depth      = FB_DEPTH_DEFAULT,
    parameter int unsigned FetchWidth = FETCH_WIDTH,
    parameter int unsigned VLen       = VLEN
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    icache_fetch_buffer_if.slave        bus,
    output logic                        busy_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);

    fb_state_e             state_q, state_d;
    logic [CntW-1:0]       infl_q, infl_d;
    logic [CntW-1:0]       occ;
    logic [CntW:0]         used;
    logic                  credit_nz, running, acc, push, pop, head_valid;
    logic                  fifo_full, fifo_empty;
    fetch_entry_t          push_entry, head_entry;
    logic [FetchWidth-1:0] head_data;
    logic [VLen-1:0]       head_vaddr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FB_RUN;
            infl_q  <= '0;
        end else begin
            state_q <= state_d;
            infl_q  <= infl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FB_RUN:   state_d = flush_i ? FB_FLUSH : FB_RUN;
            FB_FLUSH: state_d = flush_i ? FB_FLUSH : FB_RUN;
            default:  state_d = FB_RUN;
        endcase
    end

    assign used      = {1'b0, occ} + {1'b0, infl_q};
    assign credit_nz = (used != (CntW + 1)'(Depth));

    // Flush cycle and FLUSH state both block requests, responses and pops.
    always_comb begin
        running              = (state_q == FB_RUN) & ~flush_i;
        bus.icache_req_o     = running & bus.req_valid_i & credit_nz;
        bus.icache_vaddr_o   = bus.req_vaddr_i;
        bus.icache_kill_s1_o = flush_i;
        bus.icache_kill_s2_o = flush_i | (state_q == FB_FLUSH);
        acc                  = bus.icache_req_o & bus.icache_ready_i;
        bus.req_ready_o      = acc;
        push                 = running & bus.icache_valid_i & (infl_q != '0);
        head_valid           = running & ~fifo_empty;
        pop                  = head_valid & bus.fetch_ready_i;
        busy_o               = (occ != '0) | (infl_q != '0) | (state_q == FB_FLUSH);
    end

    always_comb begin
        infl_d = infl_q;
        if (flush_i) begin
            infl_d = '0;
        end else begin
            case ({acc, push})
                2'b10:   infl_d = infl_q + 1'b1;
                2'b01:   infl_d = infl_q - 1'b1;
                default: infl_d = infl_q;
            endcase
        end
    end

    always_comb begin
        push_entry.data  = bus.icache_data_i;
        push_entry.vaddr = bus.icache_vaddr_i;
        push_entry.ex    = bus.icache_ex_i;
        head_data        = head_entry.data;
        head_vaddr       = head_entry.vaddr;
        bus.fetch_valid_o = head_valid;
        bus.fetch_data_o  = head_valid ? head_data  : '0;
        bus.fetch_vaddr_o = head_valid ? head_vaddr : '0;
        bus.fetch_ex_o    = head_valid & head_entry.ex;
    end

    fetch_fifo #(
        .Depth   (Depth),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occ)
    );

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> !fifo_full);
    a_no_spurious_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.icache_valid_i && running) |-> (infl_q != '0));
    a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        used <= (CntW + 1)'(Depth));

endmodule

// File: tb/tb_icache_fetch_buffer.sv
// Directed bench for icache_fetch_buffer: per-cycle vector table for the
// streaming case plus hand-written full, flush, exception, wrap and reset runs.
module tb_icache_fetch_buffer;
    import icache_fetch_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] DKEY  = 32'hCAFE_0000;

    logic clk_i = 1'b0;
    logic rst_i;
    logic flush_i;
    logic busy_o;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned cyc    = 0;
    int unsigned lat    = 2;
    int unsigned n_acc  = 0;
    logic [63:0] pc     = '0;

    typedef struct { logic [63:0] vaddr; int unsigned due; } pend_t;
    typedef struct { logic [63:0] vaddr; logic [31:0] data; logic ex; } got_t;
    typedef struct { logic rv; logic fr; logic rr; logic fv; logic [63:0] va; logic busy; } vec_t;

    pend_t pend[$];
    got_t  got[$];
    vec_t  tbl [8];

    icache_fetch_buffer_if #(.FetchWidth(32), .VLen(64)) bus ();

    icache_fetch_buffer #(
        .Depth      (DEPTH),
        .FetchWidth (32),
        .VLen       (64)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .bus     (bus),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk1(input string nm, input logic act, input logic want);
        total++;
        if (act !== want) $display("FAIL %s: got %0b expected %0b", nm, act, want);
        else passed++;
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
        else passed++;
    endtask

    // I$ model: in-order responses `lat` cycles after acceptance.
    task automatic drive_cycle();
        logic [63:0] va;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            va = pend[0].vaddr;
            bus.icache_valid_i = 1'b1;
            bus.icache_vaddr_i = va;
            bus.icache_data_i  = va[31:0] ^ DKEY;
            bus.icache_ex_i    = (va == 64'h2000);
            void'(pend.pop_front());
        end else begin
            bus.icache_valid_i = 1'b0;
            bus.icache_vaddr_i = '0;
            bus.icache_data_i  = '0;
            bus.icache_ex_i    = 1'b0;
        end
        bus.req_vaddr_i = pc;
        #4;
    endtask

    task automatic finish_cycle();
        if (bus.req_ready_o) begin
            pend.push_back('{vaddr: pc, due: cyc + lat});
            pc = pc + 64'd4;
            n_acc++;
        end
        if (bus.fetch_valid_o && bus.fetch_ready_i)
            got.push_back('{vaddr: bus.fetch_vaddr_o, data: bus.fetch_data_o, ex: bus.fetch_ex_o});
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic run_cycles(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            drive_cycle();
            finish_cycle();
        end
    endtask

    task automatic do_reset();
        rst_i              = 1'b1;
        flush_i            = 1'b0;
        bus.req_valid_i    = 1'b0;
        bus.req_vaddr_i    = '0;
        bus.icache_ready_i = 1'b1;
        bus.icache_valid_i = 1'b0;
        bus.icache_data_i  = '0;
        bus.icache_vaddr_i = '0;
        bus.icache_ex_i    = 1'b0;
        bus.fetch_ready_i  = 1'b0;
        pend.delete();
        got.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc   = 0;
        n_acc = 0;
    endtask

    initial begin
        logic [31:0] ed;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0,    1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0,    1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0,    1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h1000, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h1004, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h1008, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h100C, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,    1'b0};

        // Reset state, then an I$ that is not ready must not accept.
        do_reset();
        drive_cycle();
        chk1("rst_req_ready", bus.req_ready_o, 1'b0);
        chk1("rst_icache_req", bus.icache_req_o, 1'b0);
        chk1("rst_kill_s1", bus.icache_kill_s1_o, 1'b0);
        chk1("rst_kill_s2", bus.icache_kill_s2_o, 1'b0);
        chk1("rst_fetch_valid", bus.fetch_valid_o, 1'b0);
        chk64("rst_fetch_data", 64'(bus.fetch_data_o), 64'h0);
        chk64("rst_fetch_vaddr", bus.fetch_vaddr_o, 64'h0);
        chk1("rst_fetch_ex", bus.fetch_ex_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        bus.req_valid_i    = 1'b1;
        bus.icache_ready_i = 1'b0;
        #1;
        chk1("notready_req", bus.icache_req_o, 1'b1);
        chk1("notready_accept", bus.req_ready_o, 1'b0);
        finish_cycle();

        // Streaming with latency 2: table of per-cycle expectations.
        do_reset();
        pc  = 64'h1000;
        lat = 2;
        for (int i = 0; i < 8; i++) begin
            bus.req_valid_i   = tbl[i].rv;
            bus.fetch_ready_i = tbl[i].fr;
            drive_cycle();
            if (i == 0) chk64("t1_icache_vaddr", bus.icache_vaddr_o, 64'h1000);
            chk1($sformatf("t1_req_ready[%0d]", i), bus.req_ready_o, tbl[i].rr);
            chk1($sformatf("t1_icache_req[%0d]", i), bus.icache_req_o, tbl[i].rr);
            chk1($sformatf("t1_fetch_valid[%0d]", i), bus.fetch_valid_o, tbl[i].fv);
            chk1($sformatf("t1_busy[%0d]", i), busy_o, tbl[i].busy);
            if (tbl[i].fv) begin
                ed = tbl[i].va[31:0] ^ DKEY;
                chk64($sformatf("t1_vaddr[%0d]", i), bus.fetch_vaddr_o, tbl[i].va);
                chk64($sformatf("t1_data[%0d]", i), 64'(bus.fetch_data_o), 64'(ed));
            end
            finish_cycle();
        end

        // Full: exactly Depth accepts; a pop frees credit only the next cycle.
        do_reset();
        pc  = 64'h1000;
        lat = 2;
        bus.req_valid_i   = 1'b1;
        bus.fetch_ready_i = 1'b0;
        run_cycles(7);
        chk64("t2_accepts", 64'(n_acc), 64'd4);
        drive_cycle();
        chk1("t2_full_ready", bus.req_ready_o, 1'b0);
        chk1("t2_full_valid", bus.fetch_valid_o, 1'b1);
        finish_cycle();
        bus.fetch_ready_i = 1'b1;
        drive_cycle();
        chk1("t2_pop_same_cycle", bus.req_ready_o, 1'b0);
        chk64("t2_head", bus.fetch_vaddr_o, 64'h1000);
        finish_cycle();
        bus.fetch_ready_i = 1'b0;
        drive_cycle();
        chk1("t2_credit_next", bus.req_ready_o, 1'b1);
        finish_cycle();
        drive_cycle();
        chk1("t2_refull", bus.req_ready_o, 1'b0);
        finish_cycle();
        bus.req_valid_i   = 1'b0;
        bus.fetch_ready_i = 1'b1;
        run_cycles(8);
        chk64("t2_count", 64'(got.size()), 64'd5);
        for (int i = 0; i < got.size(); i++)
            chk64($sformatf("t2_order[%0d]", i), got[i].vaddr, 64'h1000 + 64'(4 * i));

        // Flush with occ=2, infl=2.
        do_reset();
        pc  = 64'h1000;
        lat = 2;
        bus.req_valid_i   = 1'b1;
        bus.fetch_ready_i = 1'b0;
        run_cycles(4);
        flush_i           = 1'b1;
        bus.fetch_ready_i = 1'b1;
        drive_cycle();
        chk1("t3_kill_s1", bus.icache_kill_s1_o, 1'b1);
        chk1("t3_kill_s2", bus.icache_kill_s2_o, 1'b1);
        chk1("t3_req_blocked", bus.icache_req_o, 1'b0);
        chk1("t3_valid_forced", bus.fetch_valid_o, 1'b0);
        chk1("t3_busy", busy_o, 1'b1);
        finish_cycle();
        flush_i = 1'b0;
        pc      = 64'h3000;
        drive_cycle();
        chk1("t3f_kill_s1", bus.icache_kill_s1_o, 1'b0);
        chk1("t3f_kill_s2", bus.icache_kill_s2_o, 1'b1);
        chk1("t3f_req_blocked", bus.icache_req_o, 1'b0);
        chk1("t3f_valid", bus.fetch_valid_o, 1'b0);
        chk1("t3f_busy", busy_o, 1'b1);
        finish_cycle();
        drive_cycle();
        chk1("t3r_accept", bus.req_ready_o, 1'b1);
        chk1("t3r_busy", busy_o, 1'b0);
        chk1("t3r_valid", bus.fetch_valid_o, 1'b0);
        finish_cycle();
        bus.req_valid_i = 1'b0;
        run_cycles(5);
        chk64("t3_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk64("t3_first", got[0].vaddr, 64'h3000);

        // Exception passes through for its own entry only.
        do_reset();
        pc  = 64'h2000;
        lat = 2;
        bus.req_valid_i   = 1'b1;
        bus.fetch_ready_i = 1'b1;
        run_cycles(2);
        bus.req_valid_i = 1'b0;
        run_cycles(5);
        chk64("t4_count", 64'(got.size()), 64'd2);
        if (got.size() > 1) begin
            chk64("t4_vaddr0", got[0].vaddr, 64'h2000);
            chk1("t4_ex0", got[0].ex, 1'b1);
            chk64("t4_data0", 64'(got[0].data), 64'hCAFE_2000);
            chk64("t4_vaddr1", got[1].vaddr, 64'h2004);
            chk1("t4_ex1", got[1].ex, 1'b0);
        end

        // Sustained push+pop across several pointer wraps, latency 1.
        do_reset();
        pc  = 64'h4000;
        lat = 1;
        bus.req_valid_i   = 1'b1;
        bus.fetch_ready_i = 1'b0;
        run_cycles(3);
        bus.fetch_ready_i = 1'b1;
        run_cycles(10);
        bus.req_valid_i = 1'b0;
        run_cycles(6);
        chk64("t5_accepts", 64'(n_acc), 64'd13);
        chk64("t5_count", 64'(got.size()), 64'd13);
        for (int i = 0; i < got.size(); i++) begin
            ed = (32'h4000 + 32'(4 * i)) ^ DKEY;
            chk64($sformatf("t5_vaddr[%0d]", i), got[i].vaddr, 64'h4000 + 64'(4 * i));
            chk64($sformatf("t5_data[%0d]", i), 64'(got[i].data), 64'(ed));
        end

        // Reset while full discards everything.
        do_reset();
        pc  = 64'h5000;
        lat = 2;
        bus.req_valid_i   = 1'b1;
        bus.fetch_ready_i = 1'b0;
        run_cycles(8);
        rst_i = 1'b1;
        drive_cycle();
        chk1("t6_full_before", bus.req_ready_o, 1'b0);
        finish_cycle();
        rst_i = 1'b0;
        got.delete();
        drive_cycle();
        chk1("t6_valid", bus.fetch_valid_o, 1'b0);
        chk1("t6_busy", busy_o, 1'b0);
        chk1("t6_ready", bus.req_ready_o, 1'b1);
        finish_cycle();
        bus.req_valid_i   = 1'b0;
        bus.fetch_ready_i = 1'b1;
        run_cycles(5);
        chk64("t6_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk64("t6_first", got[0].vaddr, 64'h5010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/icache_fetch_buffer.md
Name: icache_fetch_buffer

Overview:
- Credit-managed fetch buffer directly downstream of the L1I$ data-request port.
- Issues fetch requests to the I$ on behalf of the PC generator. Queues returned fetch words (data, vaddr, exception) in a FIFO and presents them to the instruction realigner with valid/ready.
- Needed because the I$ response path has no backpressure: a request may only be issued when a FIFO slot is reserved for its response.

Parameters:
- Depth, 4, FIFO entries; power of two, >= 2
- FetchWidth, 32, fetch word width in bits (matches FETCH_WIDTH)
- VLen, 64, virtual address width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  discard all queued and in-flight fetches
- req_valid_i  in  1  PC gen fetch request
- req_vaddr_i  in  VLen  fetch address
- req_ready_o  out  1  request accepted this cycle
- icache_req_o  out  1  request to I$ (dreq_i.req)
- icache_vaddr_o  out  VLen  address to I$
- icache_kill_s1_o  out  1  kill I$ stage 1
- icache_kill_s2_o  out  1  kill I$ stage 2
- icache_ready_i  in  1  I$ can accept (dreq_o.ready)
- icache_valid_i  in  1  I$ response valid
- icache_data_i  in  FetchWidth  response data
- icache_vaddr_i  in  VLen  response vaddr
- icache_ex_i  in  1  response carries fetch exception
- fetch_valid_o  out  1  head entry valid
- fetch_data_o  out  FetchWidth  head data
- fetch_vaddr_o  out  VLen  head vaddr
- fetch_ex_o  out  1  head exception flag
- fetch_ready_i  in  1  consumer pops head
- busy_o  out  1  occupancy or in-flight count nonzero

Behaviour:
- Reset values: all outputs 0; FIFO empty; counters 0; state RUN. Reset mid-operation discards everything with no output glitch the following cycle.
- Counters:
  - occ = FIFO occupancy; infl = requests accepted but not yet answered.
  - Both are $clog2(Depth+1) bits; occ+infl <= Depth always.
  - credit = Depth - occ - infl.
- Request path (RUN): icache_req_o = req_valid_i & credit!=0; icache_vaddr_o = req_vaddr_i (combinational).
- Accept condition: acc = icache_req_o & icache_ready_i. req_ready_o = acc. acc increments infl.
- Response path:
  - icache_valid_i pushes {data, vaddr, ex} at the tail and decrements infl.
  - fetch_valid_o is asserted the next cycle at the earliest; there is no fall-through.
  - Push order equals request order; the I$ returns in order.
- Pop: fetch_valid_o & fetch_ready_i removes the head.
- Simultaneous events:
  - Push and pop in the same cycle leave occ unchanged.
  - Accept and response in the same cycle leave infl unchanged.
  - A pop frees credit in the following cycle, not the same cycle (no combinational ready path from fetch_ready_i to req_ready_o).
- Full: occ==Depth implies credit==0, so req_ready_o=0. A push while full is impossible by construction; assertion fires.
- Spurious response: icache_valid_i while infl==0 in RUN is dropped; assertion fires.
- Exceptions are passed through unchanged; fetching continues afterward.
- FSM states RUN and FLUSH:
  - RUN -> FLUSH on flush_i.
    - In the flush cycle: icache_kill_s1_o=icache_kill_s2_o=1; icache_req_o=0; occ, infl and the pointers clear at the next edge.
    - A pop offered in the flush cycle is ignored: fetch_valid_o is forced 0 in the flush cycle.
  - FLUSH (exactly one cycle): icache_kill_s2_o=1; icache_req_o=0; icache_valid_i ignored. -> RUN.
  - flush_i asserted while in FLUSH restarts FLUSH (stays one more cycle).
- Pointers are log2(Depth) bits and wrap modulo Depth.
- busy_o = (occ!=0) | (infl!=0) | state==FLUSH.

Decomposition:
- A fetch_entry_t struct {data, vaddr, ex} goes in ariane_pkg next to the icache_dreq types, as do the FSM state enum and the default Depth constant.
- One sub-module, fetch_fifo: a generic synchronous FIFO with push, pop, flush, full, empty and a count output.
- The credit logic and FSM stay in the top module.

Test Plan:
- Reset, then req_valid_i=1, icache_ready_i=1, I$ latency 2 cycles, fetch_ready_i=1 -> 4 back-to-back accepts.
  - fetch_valid_o first high 3 cycles after the first accept; vaddrs 0x1000,0x1004,0x1008,0x100C in order.
- fetch_ready_i=0, continuous requests -> exactly 4 accepts, then req_ready_o=0. After one pop, req_ready_o=1 on the next cycle only.
- flush_i with occ=2, infl=2 -> kill_s1/kill_s2 high in the flush cycle and kill_s2 high the next. A response in the FLUSH cycle is dropped; fetch_valid_o=0. The next accepted request is the first one delivered.
- Response with icache_ex_i=1 at vaddr 0x2000 -> fetch_ex_o=1 for that entry only; the subsequent entry 0x2004 has ex=0.
- Simultaneous push and pop at occ=3 for 10 cycles -> occ stays 3, data order preserved, pointers wrap correctly.
- rst_i asserted with occ=4 -> next cycle fetch_valid_o=0, busy_o=0, req_ready_o follows credit=Depth.
